// File: rtl/axi_arb_pkg.sv
// Shared types and default widths for the two-master AXI read arbiter.
package axi_arb_pkg;

    localparam int ID_W_DEF   = 4;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 4;
    localparam int SIZE_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    // Index of a requesting master: 0 = instruction fetch, 1 = data access.
    typedef logic mst_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; on a tie the master not served last wins.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_idx_t   last,
    output mst_idx_t   winner
);

    // NOTE: winner gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read path between two masters, one burst in flight at a time.
// The grant is held until the final R beat; the slave-side ID carries the master index.
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ID_W   = ID_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int SIZE_W = SIZE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   ARID_M0,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [LEN_W-1:0]  ARLEN_M0,
    input  logic [SIZE_W-1:0] ARSIZE_M0,
    input  logic [1:0]        ARBURST_M0,
    input  logic              ARVALID_M0,
    output logic              ARREADY_M0,
    output logic [ID_W-1:0]   RID_M0,
    output logic [DATA_W-1:0] RDATA_M0,
    output logic [1:0]        RRESP_M0,
    output logic              RLAST_M0,
    output logic              RVALID_M0,
    input  logic              RREADY_M0,

    input  logic [ID_W-1:0]   ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [LEN_W-1:0]  ARLEN_M1,
    input  logic [SIZE_W-1:0] ARSIZE_M1,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M1,
    output logic [ID_W-1:0]   RID_M1,
    output logic [DATA_W-1:0] RDATA_M1,
    output logic [1:0]        RRESP_M1,
    output logic              RLAST_M1,
    output logic              RVALID_M1,
    input  logic              RREADY_M1,

    output logic [ID_W:0]     ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [LEN_W-1:0]  ARLEN_S,
    output logic [SIZE_W-1:0] ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S,
    input  logic              ARREADY_S,
    input  logic [ID_W:0]     RID_S,
    input  logic [DATA_W-1:0] RDATA_S,
    input  logic [1:0]        RRESP_S,
    input  logic              RLAST_S,
    input  logic              RVALID_S,
    output logic              RREADY_S,

    output logic              busy,
    output logic              rid_err
);

    arb_state_e state_q, state_d;
    mst_idx_t   grant_q, grant_d;
    mst_idx_t   last_q,  last_d;
    logic       rid_err_q, rid_err_d;
    mst_idx_t   rr_winner;

    logic in_addr;
    logic in_data;
    logic r_handshake;

    rr_arb2 u_rr_arb2 (
        .req    ({ARVALID_M1, ARVALID_M0}),
        .last   (last_q),
        .winner (rr_winner)
    );

    assign in_addr     = (state_q == ST_ADDR);
    assign in_data     = (state_q == ST_DATA);
    assign r_handshake = in_data && RVALID_S && RREADY_S;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        rid_err_d = rid_err_q;
        case (state_q)
            ST_IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    grant_d = rr_winner;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ARREADY_S) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // A mismatched response ID is flagged but the beat is still routed by grant.
                if (RVALID_S && (RID_S[ID_W] != grant_q)) begin
                    rid_err_d = 1'b1;
                end
                if (r_handshake && RLAST_S) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            rid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            rid_err_q <= rid_err_d;
        end
    end

    // AR channel: fields follow the held grant; only the granted master sees ARREADY.
    assign ARVALID_S  = in_addr;
    assign ARID_S     = {grant_q, (grant_q ? ARID_M1 : ARID_M0)};
    assign ARADDR_S   = grant_q ? ARADDR_M1  : ARADDR_M0;
    assign ARLEN_S    = grant_q ? ARLEN_M1   : ARLEN_M0;
    assign ARSIZE_S   = grant_q ? ARSIZE_M1  : ARSIZE_M0;
    assign ARBURST_S  = grant_q ? ARBURST_M1 : ARBURST_M0;
    assign ARREADY_M0 = in_addr && !grant_q && ARREADY_S;
    assign ARREADY_M1 = in_addr &&  grant_q && ARREADY_S;

    // R channel: payload is broadcast, the valid/ready pair connects only to the granted master.
    assign RVALID_M0 = in_data && !grant_q && RVALID_S;
    assign RVALID_M1 = in_data &&  grant_q && RVALID_S;
    assign RREADY_S  = in_data && (grant_q ? RREADY_M1 : RREADY_M0);

    assign RID_M0   = RID_S[ID_W-1:0];
    assign RID_M1   = RID_S[ID_W-1:0];
    assign RDATA_M0 = RDATA_S;
    assign RDATA_M1 = RDATA_S;
    assign RRESP_M0 = RRESP_S;
    assign RRESP_M1 = RRESP_S;
    assign RLAST_M0 = RLAST_S;
    assign RLAST_M1 = RLAST_S;

    assign busy    = (state_q != ST_IDLE);
    assign rid_err = rid_err_q;

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares one AXI read path (AR + R channels) between two masters: M0 (instruction fetch) and M1 (data access).
- Sits in the interconnect between two CPU-side AXI master bridges and the read port of one slave.
- Grants one outstanding read at a time and holds the grant until the R burst's last beat completes.
- Arbitration is round-robin; the slave-side ID is extended with the master index so responses can be checked.

Parameters:
- ID_W, 4, master-side ID width; slave-side ID is ID_W+1.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LEN_W, 4, burst length width.
- SIZE_W, 3, burst size width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- ARID_M0/ARID_M1  input  ID_W each  master read IDs.
- ARADDR_M0/ARADDR_M1  input  ADDR_W each  master read addresses.
- ARLEN_M0/ARLEN_M1  input  LEN_W each  master burst lengths.
- ARSIZE_M0/ARSIZE_M1  input  SIZE_W each  master burst sizes.
- ARBURST_M0/ARBURST_M1  input  2 each  master burst types.
- ARVALID_M0/ARVALID_M1  input  1 each  master address valid.
- ARREADY_M0/ARREADY_M1  output  1 each  address accepted.
- RID_M0/RID_M1  output  ID_W each  read ID returned to master.
- RDATA_M0/RDATA_M1  output  DATA_W each  read data.
- RRESP_M0/RRESP_M1  output  2 each  read response.
- RLAST_M0/RLAST_M1, RVALID_M0/RVALID_M1  output  1 each  last-beat flag and data valid.
- RREADY_M0/RREADY_M1  input  1 each  master ready for data.
- ARID_S  output  ID_W+1  {grant, ARID of granted master}.
- ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  output  per field  muxed AR fields.
- ARVALID_S  output  1  address valid to slave.
- ARREADY_S  input  1  slave accepts address.
- RID_S  input  ID_W+1  slave read ID.
- RDATA_S, RRESP_S, RLAST_S, RVALID_S  input  per field  slave read data channel.
- RREADY_S  output  1  ready to slave.
- busy  output  1  high in any state other than IDLE.
- rid_err  output  1  sticky flag: response ID/grant mismatch.

Behaviour:
- State machine: IDLE, ADDR, DATA. Registers: state, grant (1b), last (1b), rid_err.
- Reset (rst=0 at a clk edge): state=IDLE, grant=0, last=1, rid_err=0.
  - Resulting outputs: ARVALID_S=0, ARREADY_Mx=0, RVALID_Mx=0, RREADY_S=0, busy=0.
  - Reset mid-burst abandons the transaction; the slave is reset alongside.
- IDLE:
  - Only one ARVALID_Mx high: grant<=x.
  - Both high: grant<=~last (round-robin).
  - Either case: state<=ADDR.
  - Neither high: stay in IDLE.
  - No AR/R handshakes are possible in IDLE.
- ADDR:
  - ARVALID_S=1; AR fields muxed from the granted master.
  - ARREADY_Mgrant = ARREADY_S; the other master's ARREADY = 0.
  - On ARREADY_S=1: state<=DATA.
  - Latency: master ARVALID rising in IDLE at cycle n gives ARVALID_S=1 at n+1; zero-wait handshake completes at n+1.
- DATA:
  - RVALID_Mgrant = RVALID_S; RREADY_S = RREADY_Mgrant.
  - RDATA/RRESP/RLAST broadcast to both masters; RID_Mx = RID_S[ID_W-1:0].
  - Non-granted master sees RVALID=0.
  - On RVALID_S & RREADY_S & RLAST_S: last<=grant, state<=IDLE.
  - Next arbitration happens in that IDLE cycle, so there is a one-cycle bubble between bursts.
- ID check: any DATA-state beat with RVALID_S=1 and RID_S[ID_W]!=grant sets rid_err (cleared only by reset). Data is still routed by grant.
- RVALID_S outside DATA is ignored (RREADY_S=0).
- Masters must hold ARVALID and AR fields stable until ARREADY (AXI rule). The arbiter never retracts ARVALID_S once raised.
- Grant is stable from ADDR entry through the last R beat; the other master's ARVALID waits.
- ARLEN is passed through unchanged; burst length is tracked only via RLAST_S.

Decomposition:
- Package axi_arb_pkg: state enum {IDLE, ADDR, DATA}; master-index type; ID_W/ADDR_W/DATA_W/LEN_W/SIZE_W defaults.
- Sub-module rr_arb2: 2-requester round-robin picker. Inputs req[1:0] and last; output winner. Purely combinational, used in IDLE.

Test Plan:
- Only ARVALID_M0, addr 0x0000_0010, ARLEN=0, slave ARREADY same cycle, RDATA=0xDEADBEEF one cycle later.
  - Required: ARID_S={0,ARID_M0}; RDATA_M0=0xDEADBEEF with RVALID_M0=1; RVALID_M1=0; back in IDLE the next cycle.
- Both ARVALID high after reset.
  - Required: M0 served first; M1 granted in the IDLE cycle after M0's RLAST; M1's ARVALID_S appears the cycle after that.
- Four M1 back-to-back requests while M0 also requests continuously.
  - Required: grants alternate M0, M1, M0, M1.
- ARLEN=3 burst to M1 with RREADY_M1 toggling 1,0,1,1,0,1.
  - Required: exactly 4 beats delivered; RREADY_S mirrors RREADY_M1; state stays DATA until the 4th (RLAST) beat.
- Slave returns RID_S[ID_W]=1 while grant=0.
  - Required: rid_err=1 the next cycle; data still delivered to M0; rid_err stays 1 until rst=0.
- rst asserted (0) during DATA with ARVALID_M1 pending.
  - Required: next cycle state=IDLE, RREADY_S=0, busy=0; after release, M0 wins any tie.
